pll_ctrl: RTL and testbench
===========================

# pll_ctrl

PLL configuration and sequencing controller that drives the divider, bypass and reset pins of the `tc_pll` macro wrapper and consumes its lock indication. It runs in the reference-clock domain at the top of the clock/reset tree, brings the PLL up with default dividers after reset, and accepts runtime reprogramming through a valid/ready request. A safe sequence of bypass, reset, lock wait and switch-over is enforced, with lock timeout and lock-loss detection reported on status outputs.

## Interface
Parameters:
- DEF_REFDIV, 8'd1, refdiv applied after reset
- DEF_FBDIV, 12'd24, fbdiv applied after reset
- DEF_POSTDIV1, 4'd1, postdiv1 applied after reset
- DEF_POSTDIV2, 2'd1, postdiv2 applied after reset
- SETTLE_CYC, 8, bypass settle cycles before the PLL reset
- RST_CYC, 16, cycles the PLL reset is held low
- LOCK_TIMEOUT, 20'h3FFFF, maximum WAIT_LOCK cycles
- LOSS_FILT, 4, consecutive low-lock cycles in RUN that count as a lock loss

Ports:
- clk_i  in  1  reference clock (fref)
- rst_n_i  in  1  reset, asynchronous, active-low
- cfg_valid_i  in  1  reconfiguration request
- cfg_ready_o  out  1  request accepted when valid && ready
- cfg_refdiv_i  in  8  requested refdiv
- cfg_fbdiv_i  in  12  requested fbdiv
- cfg_postdiv1_i  in  4  requested postdiv1
- cfg_postdiv2_i  in  2  requested postdiv2
- pll_lock_i  in  1  PLL lock, asynchronous to clk_i
- refdiv_o  out  8  to PLL
- fbdiv_o  out  12  to PLL
- postdiv1_o  out  4  to PLL
- postdiv2_o  out  2  to PLL
- bp_o  out  1  PLL bypass; 1 = output follows fref
- pll_rst_n_o  out  1  PLL reset, active-low
- busy_o  out  1  sequence in progress
- locked_o  out  1  in RUN with the PLL clock selected
- timeout_o  out  1  sticky; lock not reached within LOCK_TIMEOUT
- lost_o  out  1  sticky; lock dropped while in RUN

## Operation
- pll_lock_i passes through a 2-flop synchronizer to produce lock_s.
- States and transitions:
  - BYPASS: bp_o=1. After SETTLE_CYC cycles, go to PRST.
  - PRST: pll_rst_n_o=0. Divider outputs load the pending config on entry. After RST_CYC cycles, go to WAIT_LOCK.
  - WAIT_LOCK: pll_rst_n_o=1, bp_o=1, counter increments each cycle.
    - lock_s=1: go to RUN.
    - Counter reaches LOCK_TIMEOUT: go to ERR.
  - RUN: bp_o=0, locked_o=1.
    - lock_s low for LOSS_FILT consecutive cycles: set lost_o, bp_o=1, go to WAIT_LOCK with the counter cleared. The PLL is not reset on this path.
  - ERR: bp_o=1, timeout_o=1, pll_rst_n_o=1.
- cfg_ready_o=1 only in RUN and ERR.
- An accepted request:
  - latches all four cfg fields into the pending config;
  - clears timeout_o and lost_o;
  - moves to BYPASS.
- busy_o=1 in BYPASS, PRST and WAIT_LOCK.
- Divider outputs change only on entry to PRST. They are stable in every other state.
- Reset values:
  - state=PRST, counter=0, pending config = DEF_*.
  - Divider outputs = DEF_*, bp_o=1, pll_rst_n_o=0.
  - cfg_ready_o=0, busy_o=1, locked_o=0, timeout_o=0, lost_o=0.
  - Synchronizer flops = 0.
- After reset release, bring-up runs automatically with DEF_* values. Bring-up skips BYPASS because bp_o is already 1.
- Reset asserted mid-sequence returns everything to the reset values immediately, since the reset is asynchronous. Any accepted pending config is discarded.

## Timing
- Request accepted at edge T:
  - bp_o=1 and busy_o=1 at T+1.
  - PRST entered at T+1+SETTLE_CYC; pll_rst_n_o falls and dividers update on that same edge.
  - pll_rst_n_o rises RST_CYC cycles later.
- A pll_lock_i rise reaches lock_s after 2 edges. locked_o=1 and bp_o=0 one edge after that.
- Timeout:
  - ERR is entered on the edge where the WAIT_LOCK counter equals LOCK_TIMEOUT.
  - The counter is 20 bits wide and saturates; it never wraps.
- Lock loss:
  - The loss counter clears on any lock_s=1 cycle.
  - bp_o rises on the edge after the LOSS_FILT-th consecutive low sample.
- cfg_valid_i asserted outside RUN/ERR is held off (ready=0). The requester keeps valid and data stable until accepted.
- If lock_s rises on the same cycle the counter hits LOCK_TIMEOUT, lock wins and the next state is RUN.

## Structure
- Shared package `pll_pkg`:
  - state encoding (BYPASS, PRST, WAIT_LOCK, RUN, ERR);
  - divider field widths;
  - LOCK_TIMEOUT counter width (20).
- One sub-module, `pll_lock_sync`: 2-flop synchronizer with async active-low reset to 0.
- Everything else (FSM, counters, config registers) lives in `pll_ctrl`.

## Test plan
- Reset release with SETTLE_CYC=8, RST_CYC=16, lock driven high 100 cycles after pll_rst_n_o rises:
  - pll_rst_n_o low for exactly 16 cycles with dividers at 1/24/1/1;
  - locked_o=1 and bp_o=0 exactly 3 cycles after the lock rise.
- In RUN, request refdiv=2, fbdiv=50, postdiv1=2, postdiv2=1:
  - bp_o=1 before pll_rst_n_o falls;
  - dividers change only on the pll_rst_n_o falling edge;
  - ready=0 until RUN is reached again.
- Lock never asserted with LOCK_TIMEOUT=1000: ERR after 1000 WAIT_LOCK cycles, timeout_o=1, bp_o=1, cfg_ready_o=1.
- In RUN, lock pulsed low for 3 cycles: no effect. Lock held low for 4 cycles: lost_o=1, bp_o=1, state WAIT_LOCK; re-lock returns to RUN with lost_o still 1.
- rst_n_i asserted mid-WAIT_LOCK after a reconfiguration: outputs return to reset values immediately and bring-up reruns with DEF_* values.
- lock_s rising on the timeout cycle: state RUN and timeout_o=0.

Source files
------------

// File: rtl/pll_pkg.sv
// Shared types and widths for the PLL sequencing controller.
package pll_pkg;

    localparam int unsigned REFDIV_W   = 8;
    localparam int unsigned FBDIV_W    = 12;
    localparam int unsigned POSTDIV1_W = 4;
    localparam int unsigned POSTDIV2_W = 2;
    localparam int unsigned LOCK_CNT_W = 20;

    typedef enum logic [2:0] {
        StBypass,
        StPrst,
        StWaitLock,
        StRun,
        StErr
    } pll_state_e;

    typedef struct packed {
        logic [REFDIV_W-1:0]   refdiv;
        logic [FBDIV_W-1:0]    fbdiv;
        logic [POSTDIV1_W-1:0] postdiv1;
        logic [POSTDIV2_W-1:0] postdiv2;
    } pll_cfg_t;

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock into the fref domain.
module pll_lock_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            q_o    <= 1'b0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/pll_ctrl.sv
// PLL bring-up and reprogramming sequencer: bypass, reset, lock wait, switch-over,
// with lock timeout and lock-loss reporting.
module pll_ctrl
    import pll_pkg::*;
#(
    parameter logic [REFDIV_W-1:0]   DEF_REFDIV   = 8'd1,
    parameter logic [FBDIV_W-1:0]    DEF_FBDIV    = 12'd24,
    parameter logic [POSTDIV1_W-1:0] DEF_POSTDIV1 = 4'd1,
    parameter logic [POSTDIV2_W-1:0] DEF_POSTDIV2 = 2'd1,
    parameter int unsigned           SETTLE_CYC   = 8,
    parameter int unsigned           RST_CYC      = 16,
    parameter logic [LOCK_CNT_W-1:0] LOCK_TIMEOUT = 20'h3FFFF,
    parameter int unsigned           LOSS_FILT    = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  cfg_valid_i,
    output logic                  cfg_ready_o,
    input  logic [REFDIV_W-1:0]   cfg_refdiv_i,
    input  logic [FBDIV_W-1:0]    cfg_fbdiv_i,
    input  logic [POSTDIV1_W-1:0] cfg_postdiv1_i,
    input  logic [POSTDIV2_W-1:0] cfg_postdiv2_i,
    input  logic                  pll_lock_i,
    output logic [REFDIV_W-1:0]   refdiv_o,
    output logic [FBDIV_W-1:0]    fbdiv_o,
    output logic [POSTDIV1_W-1:0] postdiv1_o,
    output logic [POSTDIV2_W-1:0] postdiv2_o,
    output logic                  bp_o,
    output logic                  pll_rst_n_o,
    output logic                  busy_o,
    output logic                  locked_o,
    output logic                  timeout_o,
    output logic                  lost_o
);

    localparam int unsigned           LOSS_W      = $clog2(LOSS_FILT + 1);
    localparam logic [LOCK_CNT_W-1:0] SETTLE_LAST = LOCK_CNT_W'(SETTLE_CYC - 1);
    localparam logic [LOCK_CNT_W-1:0] RST_LAST    = LOCK_CNT_W'(RST_CYC - 1);
    localparam logic [LOSS_W-1:0]     LOSS_LAST   = LOSS_W'(LOSS_FILT - 1);
    localparam pll_cfg_t DEF_CFG = {DEF_REFDIV, DEF_FBDIV, DEF_POSTDIV1, DEF_POSTDIV2};

    pll_state_e              state_q, state_d;
    logic [LOCK_CNT_W-1:0]   cnt_q, cnt_d;
    logic [LOSS_W-1:0]       loss_q, loss_d;
    pll_cfg_t                pend_q;
    logic                    lock_s;
    logic                    accept;
    logic                    lost_set;

    pll_lock_sync u_lock_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (pll_lock_i),
        .q_o     (lock_s)
    );

    assign accept = cfg_valid_i & cfg_ready_o;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        loss_d   = '0;
        lost_set = 1'b0;
        case (state_q)
            StBypass: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = StPrst;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StPrst: begin
                if (cnt_q == RST_LAST) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitLock: begin
                // Saturating count; a lock seen on the timeout cycle still wins.
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                if (lock_s) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else if (cnt_d >= LOCK_TIMEOUT) begin
                    state_d = StErr;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                if (!lock_s) begin
                    if (loss_q == LOSS_LAST) begin
                        state_d  = StWaitLock;
                        cnt_d    = '0;
                        lost_set = 1'b1;
                    end else begin
                        loss_d = loss_q + 1'b1;
                    end
                end
            end
            StErr: ;
            default: begin
                state_d = StPrst;
                cnt_d   = '0;
            end
        endcase
        if (accept) begin
            state_d = StBypass;
            cnt_d   = '0;
            loss_d  = '0;
        end
    end

    // Outputs are decoded from the next state so they register together with it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= StPrst;
            cnt_q       <= '0;
            loss_q      <= '0;
            pend_q      <= DEF_CFG;
            refdiv_o    <= DEF_REFDIV;
            fbdiv_o     <= DEF_FBDIV;
            postdiv1_o  <= DEF_POSTDIV1;
            postdiv2_o  <= DEF_POSTDIV2;
            bp_o        <= 1'b1;
            pll_rst_n_o <= 1'b0;
            cfg_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            locked_o    <= 1'b0;
            timeout_o   <= 1'b0;
            lost_o      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            loss_q  <= loss_d;
            if (accept) begin
                pend_q <= {cfg_refdiv_i, cfg_fbdiv_i, cfg_postdiv1_i, cfg_postdiv2_i};
            end
            if (state_d == StPrst && state_q != StPrst) begin
                refdiv_o   <= pend_q.refdiv;
                fbdiv_o    <= pend_q.fbdiv;
                postdiv1_o <= pend_q.postdiv1;
                postdiv2_o <= pend_q.postdiv2;
            end
            bp_o        <= (state_d != StRun);
            pll_rst_n_o <= (state_d != StPrst);
            cfg_ready_o <= (state_d == StRun) || (state_d == StErr);
            busy_o      <= state_d inside {StBypass, StPrst, StWaitLock};
            locked_o    <= (state_d == StRun);
            if (accept) begin
                timeout_o <= 1'b0;
                lost_o    <= 1'b0;
            end else begin
                if (state_d == StErr) timeout_o <= 1'b1;
                if (lost_set) lost_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pll_ctrl.sv
// Self-checking bench for pll_ctrl: randomized configs and lock timing against a
// cycle-count reference model derived from the sequencing rules.
module tb_pll_ctrl;

    localparam int unsigned SETTLE = 8;
    localparam int unsigned RSTC   = 16;
    localparam int unsigned LT     = 1000;
    localparam int unsigned LOSS   = 4;
    localparam logic [25:0] DEF_CFG = {8'd1, 12'd24, 4'd1, 2'd1};

    localparam int SEL_RST_HI = 0;
    localparam int SEL_RST_LO = 1;
    localparam int SEL_LOCKED = 2;
    localparam int SEL_TMO    = 3;
    localparam int SEL_BP_HI  = 4;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        cfg_valid_i = 1'b0;
    logic        cfg_ready_o;
    logic [7:0]  cfg_refdiv_i = '0;
    logic [11:0] cfg_fbdiv_i = '0;
    logic [3:0]  cfg_postdiv1_i = '0;
    logic [1:0]  cfg_postdiv2_i = '0;
    logic        pll_lock_i = 1'b0;
    logic [7:0]  refdiv_o;
    logic [11:0] fbdiv_o;
    logic [3:0]  postdiv1_o;
    logic [1:0]  postdiv2_o;
    logic        bp_o, pll_rst_n_o, busy_o, locked_o, timeout_o, lost_o;
    logic [25:0] dut_div;

    int          total = 0;
    int          bad = 0;
    logic [25:0] exp_div;
    logic [25:0] pend;

    assign dut_div = {refdiv_o, fbdiv_o, postdiv1_o, postdiv2_o};

    pll_ctrl #(
        .SETTLE_CYC   (SETTLE),
        .RST_CYC      (RSTC),
        .LOCK_TIMEOUT (20'(LT)),
        .LOSS_FILT    (LOSS)
    ) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .cfg_valid_i    (cfg_valid_i),
        .cfg_ready_o    (cfg_ready_o),
        .cfg_refdiv_i   (cfg_refdiv_i),
        .cfg_fbdiv_i    (cfg_fbdiv_i),
        .cfg_postdiv1_i (cfg_postdiv1_i),
        .cfg_postdiv2_i (cfg_postdiv2_i),
        .pll_lock_i     (pll_lock_i),
        .refdiv_o       (refdiv_o),
        .fbdiv_o        (fbdiv_o),
        .postdiv1_o     (postdiv1_o),
        .postdiv2_o     (postdiv2_o),
        .bp_o           (bp_o),
        .pll_rst_n_o    (pll_rst_n_o),
        .busy_o         (busy_o),
        .locked_o       (locked_o),
        .timeout_o      (timeout_o),
        .lost_o         (lost_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    function automatic bit hit(input int sel);
        case (sel)
            SEL_RST_HI: return pll_rst_n_o === 1'b1;
            SEL_RST_LO: return pll_rst_n_o === 1'b0;
            SEL_LOCKED: return locked_o === 1'b1;
            SEL_TMO:    return timeout_o === 1'b1;
            SEL_BP_HI:  return bp_o === 1'b1;
            default:    return 1'b0;
        endcase
    endfunction

    // Ticks until the selected event; n=-1 on expiry. Flags cover ticks before the hit.
    task automatic wait_on(input int sel, input int limit, output int n, output bit chg,
                           output bit rdy, output bit bpl);
        logic [25:0] snap;
        snap = dut_div;
        n = -1; chg = 1'b0; rdy = 1'b0; bpl = 1'b0;
        for (int i = 1; i <= limit; i++) begin
            tick;
            if (hit(sel)) begin
                n = i;
                break;
            end
            if (dut_div !== snap) chg = 1'b1;
            if (cfg_ready_o) rdy = 1'b1;
            if (!bp_o) bpl = 1'b1;
        end
    endtask

    task automatic drive_cfg(input logic [25:0] c);
        cfg_refdiv_i   = c[25:18];
        cfg_fbdiv_i    = c[17:6];
        cfg_postdiv1_i = c[5:2];
        cfg_postdiv2_i = c[1:0];
    endtask

    task automatic send_cfg(input logic [25:0] c);
        drive_cfg(c);
        cfg_valid_i = 1'b1;
        tick;
        cfg_valid_i = 1'b0;
        pend = c;
    endtask

    function automatic logic [25:0] rand_cfg();
        return {8'($urandom_range(1, 255)), 12'($urandom_range(1, 4095)),
                4'($urandom_range(1, 15)), 2'($urandom_range(1, 3))};
    endfunction

    task automatic test_reset;
        rst_n_i = 1'b0;
        pll_lock_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        exp_div = DEF_CFG;
        pend = DEF_CFG;
        total++;
        if (dut_div !== exp_div) begin
            bad++; $display("FAIL reset_div got=%h want=%h", dut_div, exp_div);
        end
        total++;
        if ({bp_o, pll_rst_n_o, cfg_ready_o, busy_o, locked_o, timeout_o, lost_o} !== 7'b1001000) begin
            bad++;
            $display("FAIL reset_flags got=%b want=1001000",
                     {bp_o, pll_rst_n_o, cfg_ready_o, busy_o, locked_o, timeout_o, lost_o});
        end
    endtask

    task automatic test_bringup;
        int n; bit chg, rdy, bpl;
        rst_n_i = 1'b1;
        wait_on(SEL_RST_HI, 100, n, chg, rdy, bpl);
        total++;
        if (n != RSTC) begin bad++; $display("FAIL bringup_rst_len got=%0d want=%0d", n, RSTC); end
        total++;
        if ({chg, dut_div} !== {1'b0, exp_div}) begin
            bad++; $display("FAIL bringup_div got=%b/%h want=0/%h", chg, dut_div, exp_div);
        end
        repeat (100) tick;
        pll_lock_i = 1'b1;
        wait_on(SEL_LOCKED, 20, n, chg, rdy, bpl);
        total++;
        if (n != 3) begin bad++; $display("FAIL bringup_lock_lat got=%0d want=3", n); end
        total++;
        if ({bp_o, busy_o, cfg_ready_o, pll_rst_n_o} !== 4'b0011) begin
            bad++; $display("FAIL bringup_run got=%b want=0011", {bp_o, busy_o, cfg_ready_o, pll_rst_n_o});
        end
    endtask

    task automatic test_reconfig(input logic [25:0] c);
        int n, d; bit chg, rdy, bpl, rdy_any;
        send_cfg(c);
        total++;
        if ({bp_o, busy_o, cfg_ready_o, locked_o} !== 4'b1100) begin
            bad++; $display("FAIL reconfig_accept got=%b want=1100", {bp_o, busy_o, cfg_ready_o, locked_o});
        end
        wait_on(SEL_RST_LO, 50, n, chg, rdy, bpl);
        exp_div = pend;
        total++;
        if (n != SETTLE) begin bad++; $display("FAIL reconfig_settle got=%0d want=%0d", n, SETTLE); end
        total++;
        if ({chg, bpl, dut_div} !== {2'b00, exp_div}) begin
            bad++; $display("FAIL reconfig_div got=%b%b/%h want=00/%h", chg, bpl, dut_div, exp_div);
        end
        rdy_any = rdy;
        pll_lock_i = 1'b0;
        wait_on(SEL_RST_HI, 50, n, chg, rdy, bpl);
        rdy_any |= rdy;
        total++;
        if ({n, chg} != {RSTC, 1'b0}) begin
            bad++; $display("FAIL reconfig_rst_len got=%0d/%b want=%0d/0", n, chg, RSTC);
        end
        d = $urandom_range(0, 40);
        for (int i = 0; i < d; i++) begin
            tick;
            if (cfg_ready_o) rdy_any = 1'b1;
        end
        pll_lock_i = 1'b1;
        wait_on(SEL_LOCKED, 20, n, chg, rdy, bpl);
        rdy_any |= rdy;
        total++;
        if ({n, rdy_any} != {32'd3, 1'b0}) begin
            bad++; $display("FAIL reconfig_relock got=%0d/%b want=3/0", n, rdy_any);
        end
    endtask

    task automatic test_back_to_back;
        logic [25:0] c1, c2;
        int n; bit chg, rdy, bpl;
        c1 = rand_cfg();
        c2 = rand_cfg();
        send_cfg(c1);
        drive_cfg(c2);
        cfg_valid_i = 1'b1;
        wait_on(SEL_RST_LO, 50, n, chg, rdy, bpl);
        exp_div = pend;
        total++;
        if ({n, dut_div} !== {SETTLE, exp_div}) begin
            bad++; $display("FAIL b2b_first got=%0d/%h want=%0d/%h", n, dut_div, SETTLE, exp_div);
        end
        pll_lock_i = 1'b0;
        wait_on(SEL_RST_HI, 50, n, chg, rdy, bpl);
        pll_lock_i = 1'b1;
        wait_on(SEL_LOCKED, 20, n, chg, rdy, bpl);
        tick;
        cfg_valid_i = 1'b0;
        pend = c2;
        total++;
        if ({bp_o, busy_o, locked_o} !== 3'b110) begin
            bad++; $display("FAIL b2b_second_accept got=%b want=110", {bp_o, busy_o, locked_o});
        end
        wait_on(SEL_RST_LO, 50, n, chg, rdy, bpl);
        exp_div = pend;
        total++;
        if ({n, dut_div} !== {SETTLE, exp_div}) begin
            bad++; $display("FAIL b2b_second got=%0d/%h want=%0d/%h", n, dut_div, SETTLE, exp_div);
        end
        pll_lock_i = 1'b0;
        wait_on(SEL_RST_HI, 50, n, chg, rdy, bpl);
        pll_lock_i = 1'b1;
        wait_on(SEL_LOCKED, 20, n, chg, rdy, bpl);
    endtask

    task automatic test_lock_loss;
        int n, g; bit chg, rdy, bpl;
        g = $urandom_range(1, LOSS - 1);
        pll_lock_i = 1'b0;
        repeat (g) tick;
        pll_lock_i = 1'b1;
        repeat (6) tick;
        total++;
        if ({locked_o, bp_o, lost_o, busy_o} !== 4'b1000) begin
            bad++; $display("FAIL loss_glitch%0d got=%b want=1000", g, {locked_o, bp_o, lost_o, busy_o});
        end
        pll_lock_i = 1'b0;
        wait_on(SEL_BP_HI, 20, n, chg, rdy, bpl);
        total++;
        if (n != LOSS + 2) begin bad++; $display("FAIL loss_latency got=%0d want=%0d", n, LOSS + 2); end
        repeat (10) tick;
        total++;
        if ({lost_o, bp_o, busy_o, locked_o, pll_rst_n_o} !== 5'b11101) begin
            bad++;
            $display("FAIL loss_wait got=%b want=11101", {lost_o, bp_o, busy_o, locked_o, pll_rst_n_o});
        end
        pll_lock_i = 1'b1;
        wait_on(SEL_LOCKED, 20, n, chg, rdy, bpl);
        total++;
        if ({n, lost_o, bp_o} != {32'd3, 2'b10}) begin
            bad++; $display("FAIL loss_relock got=%0d/%b%b want=3/10", n, lost_o, bp_o);
        end
    endtask

    task automatic test_timeout;
        int n; bit chg, rdy, bpl;
        send_cfg(rand_cfg());
        total++;
        if (lost_o !== 1'b0) begin bad++; $display("FAIL tmo_lost_clear got=%b want=0", lost_o); end
        wait_on(SEL_RST_LO, 50, n, chg, rdy, bpl);
        exp_div = pend;
        pll_lock_i = 1'b0;
        wait_on(SEL_RST_HI, 50, n, chg, rdy, bpl);
        wait_on(SEL_TMO, 2 * LT, n, chg, rdy, bpl);
        total++;
        if (n != LT) begin bad++; $display("FAIL tmo_len got=%0d want=%0d", n, LT); end
        total++;
        if ({bp_o, cfg_ready_o, busy_o, locked_o, pll_rst_n_o, timeout_o} !== 6'b110011) begin
            bad++;
            $display("FAIL tmo_err got=%b want=110011",
                     {bp_o, cfg_ready_o, busy_o, locked_o, pll_rst_n_o, timeout_o});
        end
    endtask

    task automatic test_timeout_race;
        int n; bit chg, rdy, bpl;
        // Lock one cycle too late: still a timeout.
        send_cfg(rand_cfg());
        total++;
        if (timeout_o !== 1'b0) begin bad++; $display("FAIL race_tmo_clear got=%b want=0", timeout_o); end
        wait_on(SEL_RST_LO, 50, n, chg, rdy, bpl);
        pll_lock_i = 1'b0;
        wait_on(SEL_RST_HI, 50, n, chg, rdy, bpl);
        repeat (LT - 2) tick;
        pll_lock_i = 1'b1;
        wait_on(SEL_TMO, 5, n, chg, rdy, bpl);
        total++;
        if ({n, locked_o} != {32'd2, 1'b0}) begin
            bad++; $display("FAIL race_late got=%0d/%b want=2/0", n, locked_o);
        end
        // Lock reaching lock_s exactly on the timeout cycle wins.
        send_cfg(rand_cfg());
        wait_on(SEL_RST_LO, 50, n, chg, rdy, bpl);
        pll_lock_i = 1'b0;
        wait_on(SEL_RST_HI, 50, n, chg, rdy, bpl);
        repeat (LT - 3) tick;
        pll_lock_i = 1'b1;
        repeat (3) tick;
        total++;
        if ({locked_o, timeout_o, bp_o} !== 3'b100) begin
            bad++; $display("FAIL race_exact got=%b want=100", {locked_o, timeout_o, bp_o});
        end
    endtask

    task automatic test_async_reset;
        int n; bit chg, rdy, bpl;
        send_cfg(rand_cfg());
        wait_on(SEL_RST_LO, 50, n, chg, rdy, bpl);
        pll_lock_i = 1'b0;
        wait_on(SEL_RST_HI, 50, n, chg, rdy, bpl);
        repeat ($urandom_range(5, 50)) tick;
        #3 rst_n_i = 1'b0;
        #1;
        exp_div = DEF_CFG;
        pend = DEF_CFG;
        total++;
        if (dut_div !== exp_div) begin
            bad++; $display("FAIL arst_div got=%h want=%h", dut_div, exp_div);
        end
        total++;
        if ({bp_o, pll_rst_n_o, cfg_ready_o, busy_o, locked_o, timeout_o, lost_o} !== 7'b1001000) begin
            bad++;
            $display("FAIL arst_flags got=%b want=1001000",
                     {bp_o, pll_rst_n_o, cfg_ready_o, busy_o, locked_o, timeout_o, lost_o});
        end
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        wait_on(SEL_RST_HI, 100, n, chg, rdy, bpl);
        total++;
        if ({n, chg, dut_div} !== {RSTC, 1'b0, exp_div}) begin
            bad++; $display("FAIL arst_bringup got=%0d/%b/%h want=%0d/0/%h", n, chg, dut_div, RSTC, exp_div);
        end
        pll_lock_i = 1'b1;
        wait_on(SEL_LOCKED, 20, n, chg, rdy, bpl);
        total++;
        if (n != 3) begin bad++; $display("FAIL arst_relock got=%0d want=3", n); end
    endtask

    initial begin
        logic [25:0] spec_cfg;
        spec_cfg = {8'd2, 12'd50, 4'd2, 2'd1};
        test_reset;
        test_bringup;
        test_reconfig(spec_cfg);
        for (int i = 0; i < 2; i++) test_reconfig(rand_cfg());
        test_back_to_back;
        test_lock_loss;
        test_timeout;
        test_timeout_race;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
